// File: rtl/hilo_pair_reg.sv
// HI/LO result register pair fed by the mul/div unit and the datapath bus.
// Tracks an outstanding operation, stalls HI/LO access while it is pending, and times out lost results.
module hilo_pair_reg #(
    parameter int WIDTH   = 32,
    parameter int MAX_LAT = 40,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               pair_we,
    input  logic [2*WIDTH-1:0] pair_d,
    input  logic               lo_we,
    input  logic               hi_we,
    input  logic [WIDTH-1:0]   bus_d,
    input  logic               rd_req,
    output logic [WIDTH-1:0]   Q_low,
    output logic [WIDTH-1:0]   Q_high,
    output logic               busy,
    output logic               stall,
    output logic               err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Last pending cycle in which a result is still accepted; the edge after it times out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_nxt_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             busy_s;
    logic             stall_s;
    logic             bus_wr_s;
    logic             timeout_s;

    assign bus_wr_s  = lo_we | hi_we;
    assign timeout_s = (cnt_r == CNT_LAST);

    // State and watchdog counter register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and watchdog counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (start) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PENDING: begin
                if (pair_we) begin
                    // A new start alongside the result chains straight into the next op.
                    cnt_nxt_s = CNT_ZERO;
                    if (start) begin
                        state_nxt_s = PENDING;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = PENDING;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy_s  = (state_r == PENDING);
        stall_s = busy_s & (rd_req | bus_wr_s);
    end

    // Next values of the halves and the sticky error flag
    always_comb begin
        lo_nxt_s  = lo_r;
        hi_nxt_s  = hi_r;
        err_nxt_s = err_r;
        case (state_r)
            IDLE: begin
                if (pair_we) begin
                    lo_nxt_s = pair_d[WIDTH-1:0];
                    hi_nxt_s = pair_d[2*WIDTH-1:WIDTH];
                end else begin
                    if (lo_we) begin
                        lo_nxt_s = bus_d;
                    end else begin
                        lo_nxt_s = lo_r;
                    end
                    if (hi_we) begin
                        hi_nxt_s = bus_d;
                    end else begin
                        hi_nxt_s = hi_r;
                    end
                end
            end
            PENDING: begin
                if (pair_we) begin
                    lo_nxt_s = pair_d[WIDTH-1:0];
                    hi_nxt_s = pair_d[2*WIDTH-1:WIDTH];
                end else begin
                    lo_nxt_s = lo_r;
                    hi_nxt_s = hi_r;
                end
                // Bus writes ignoring stall, stray starts and timeouts are all flagged.
                if (bus_wr_s | (~pair_we & (start | timeout_s))) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            default: begin
                lo_nxt_s  = lo_r;
                hi_nxt_s  = hi_r;
                err_nxt_s = err_r;
            end
        endcase
    end

    // Result halves and error flag registers
    always_ff @(posedge clk) begin
        if (clr) begin
            lo_r  <= {WIDTH{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            err_r <= 1'b0;
        end else begin
            lo_r  <= lo_nxt_s;
            hi_r  <= hi_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign Q_low  = lo_r;
    assign Q_high = hi_r;
    assign busy   = busy_s;
    assign stall  = stall_s;
    assign err    = err_r;

endmodule
